// File: rtl/decoder_pkg.sv
// Shared constants and one-hot helpers for the 3-to-8 decoder slice.
package decoder_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  // One-hot decode of a binary index, gated by an enable.
  function automatic logic [OUT_W-1:0] onehot_dec(input logic [SEL_W-1:0] sel,
                                                  input logic             en);
    logic [OUT_W-1:0] v;
    v = '0;
    if (en) begin
      v[sel] = 1'b1;
    end
    return v;
  endfunction

  // True when more than one bit is set (zero and one-hot are both legal).
  function automatic logic multi_hot(input logic [OUT_W-1:0] v);
    return |(v & (v - OUT_W'(1)));
  endfunction

endpackage

// File: rtl/decoder_3to8_if.sv
// Bus bundle between the decoder and whoever drives/observes it.
interface decoder_3to8_if #(
  parameter int CNT_W = 16
);
  import decoder_pkg::*;

  logic [SEL_W-1:0] select;
  logic             enable;
  logic             clear;
  logic [OUT_W-1:0] out;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] hit_mask;
  logic [CNT_W-1:0] en_cnt;
  logic             onehot_err;

  modport master (
    output select, enable, clear,
    input  out, out_q, hit_mask, en_cnt, onehot_err
  );

  modport slave (
    input  select, enable, clear,
    output out, out_q, hit_mask, en_cnt, onehot_err
  );

endinterface

// File: rtl/decoder_3to8_dec_core.sv
// Purely combinational 3-to-8 decode; no clock or reset involvement.
module dec_core
  import decoder_pkg::*;
(
  input  logic [SEL_W-1:0] select,
  input  logic             enable,
  output logic [OUT_W-1:0] out
);

  // One-hot of select when enabled, all-zero otherwise.
  always_comb begin
    out = '0;
    out = onehot_dec(select, enable);
  end

endmodule

// File: rtl/decoder_3to8.sv
// 3-to-8 decoder with registered copy, sticky hit mask, saturating
// enable-cycle counter and a one-hot sanity flag.
module decoder_3to8
  import decoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  decoder_3to8_if.slave      bus
);

  logic [OUT_W-1:0] dec_p0;
  logic [OUT_W-1:0] out_p1;
  logic [OUT_W-1:0] hit_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             err_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  dec_core u_dec_core (
    .select (bus.select),
    .enable (bus.enable),
    .out    (dec_p0)
  );

  // p0 -> p1: capture decode and fold it into the statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_p1 <= '0;
      hit_p1 <= '0;
      cnt_p1 <= '0;
      err_p1 <= 1'b0;
    end else begin
      out_p1 <= dec_p0;
      err_p1 <= multi_hot(dec_p0);
      if (bus.clear) begin
        hit_p1 <= dec_p0;
        cnt_p1 <= {{(CNT_W-1){1'b0}}, bus.enable};
      end else begin
        hit_p1 <= hit_p1 | dec_p0;
        if (bus.enable) begin
          cnt_p1 <= sat_inc(cnt_p1);
        end
      end
    end
  end

  assign bus.out        = dec_p0;
  assign bus.out_q      = out_p1;
  assign bus.hit_mask   = hit_p1;
  assign bus.en_cnt     = cnt_p1;
  assign bus.onehot_err = err_p1;

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed bench for decoder_3to8 with a small reference model for the
// random phase.
module tb_decoder_3to8;

  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  decoder_3to8_if #(.CNT_W(CNT_W)) bus ();

  decoder_3to8 #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_out;
  logic [7:0] hit_m;
  logic [3:0] cnt_m;
  logic [2:0] rsel;
  logic       ren;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.select = 3'd0;
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    tick();
    tick();

    chk("rst_out_q",  32'(bus.out_q), 32'h00);
    chk("rst_hit",    32'(bus.hit_mask), 32'h00);
    chk("rst_cnt",    32'(bus.en_cnt), 32'h0);
    chk("rst_err",    32'(bus.onehot_err), 32'h0);

    // enable=0 sweep; out tracks inputs even while reset is held
    for (int i = 0; i < 8; i++) begin
      bus.select = 3'(i);
      #10;
      chk("dis_out", 32'(bus.out), 32'h00);
    end

    bus.enable = 1'b1;
    bus.select = 3'd0; #10; chk("en_out_000", 32'(bus.out), 32'h01);
    bus.select = 3'd1; #10; chk("en_out_001", 32'(bus.out), 32'h02);
    bus.select = 3'd2; #10; chk("en_out_010", 32'(bus.out), 32'h04);
    bus.select = 3'd3; #10; chk("en_out_011", 32'(bus.out), 32'h08);
    bus.select = 3'd4; #10; chk("en_out_100", 32'(bus.out), 32'h10);
    bus.select = 3'd5; #10; chk("en_out_101", 32'(bus.out), 32'h20);
    bus.select = 3'd6; #10; chk("en_out_110", 32'(bus.out), 32'h40);
    bus.select = 3'd7; #10; chk("en_out_111", 32'(bus.out), 32'h80);
    chk("rst_hold_cnt", 32'(bus.en_cnt), 32'h0);

    // first edges out of reset
    tick();
    rst_n = 1'b1;
    bus.enable = 1'b1;
    bus.select = 3'd2;
    tick();
    chk("seq1_out_q", 32'(bus.out_q), 32'h04);
    chk("seq1_hit",   32'(bus.hit_mask), 32'h04);
    chk("seq1_cnt",   32'(bus.en_cnt), 32'h1);
    bus.select = 3'd5;
    tick();
    chk("seq2_out_q", 32'(bus.out_q), 32'h20);
    chk("seq2_hit",   32'(bus.hit_mask), 32'h24);
    chk("seq2_cnt",   32'(bus.en_cnt), 32'h2);

    // clear with enable low
    bus.clear  = 1'b1;
    bus.enable = 1'b0;
    tick();
    chk("clr0_hit", 32'(bus.hit_mask), 32'h00);
    chk("clr0_cnt", 32'(bus.en_cnt), 32'h0);
    chk("clr0_out_q", 32'(bus.out_q), 32'h00);

    // saturation: 19 enabled cycles
    bus.clear  = 1'b0;
    bus.enable = 1'b1;
    bus.select = 3'd1;
    for (int i = 0; i < 14; i++) tick();
    chk("cnt_14", 32'(bus.en_cnt), 32'hE);
    tick();
    chk("cnt_15", 32'(bus.en_cnt), 32'hF);
    for (int i = 0; i < 4; i++) tick();
    chk("cnt_sat", 32'(bus.en_cnt), 32'hF);
    chk("sat_hit", 32'(bus.hit_mask), 32'h02);

    // clear with enable high counts the current cycle
    bus.clear  = 1'b1;
    bus.select = 3'd6;
    tick();
    chk("clr1_cnt", 32'(bus.en_cnt), 32'h1);
    chk("clr1_hit", 32'(bus.hit_mask), 32'h40);
    bus.clear  = 1'b0;
    bus.select = 3'd3;
    tick();
    chk("post_clr_hit", 32'(bus.hit_mask), 32'h48);
    chk("post_clr_cnt", 32'(bus.en_cnt), 32'h2);

    // mid-run reset, clear asserted too and ignored
    rst_n = 1'b0;
    bus.clear  = 1'b1;
    bus.select = 3'd7;
    tick();
    chk("mrst_out_q", 32'(bus.out_q), 32'h00);
    chk("mrst_hit",   32'(bus.hit_mask), 32'h00);
    chk("mrst_cnt",   32'(bus.en_cnt), 32'h0);
    chk("mrst_err",   32'(bus.onehot_err), 32'h0);
    chk("mrst_out",   32'(bus.out), 32'h80);
    rst_n = 1'b1;
    bus.clear = 1'b0;
    tick();
    chk("rel_out_q", 32'(bus.out_q), 32'h80);
    chk("rel_hit",   32'(bus.hit_mask), 32'h80);
    chk("rel_cnt",   32'(bus.en_cnt), 32'h1);

    // random phase against a reference model
    hit_m = 8'h80;
    cnt_m = 4'h1;
    for (int i = 0; i < 1000; i++) begin
      rsel = 3'($urandom_range(0, 7));
      ren  = 1'($urandom_range(0, 1));
      bus.select = rsel;
      bus.enable = ren;
      exp_out = ren ? (8'h01 << rsel) : 8'h00;
      #1;
      chk("rnd_out", 32'(bus.out), 32'(exp_out));
      hit_m = hit_m | exp_out;
      if (ren && cnt_m != 4'hF) cnt_m = cnt_m + 4'h1;
      tick();
      chk("rnd_out_q", 32'(bus.out_q), 32'(exp_out));
      chk("rnd_err",   32'(bus.onehot_err), 32'h0);
      chk("rnd_hit",   32'(bus.hit_mask), 32'(hit_m));
      chk("rnd_cnt",   32'(bus.en_cnt), 32'(cnt_m));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_3to8.md
DECODER_3TO8 -- requirements
Module: decoder_3to8

Interface
REQ-001 Parameter: CNT_W, default 16, width of the enable-cycle counter (legal range 4..32).
REQ-002 Port: clk, input, 1, single clock; all state updates on rising edge.
REQ-003 Port: rst_n, input, 1, reset, synchronous and active-low.
REQ-004 Port: select, input, 3, binary index of the output line to assert.
REQ-005 Port: enable, input, 1, decoder enable; 0 forces all decoded outputs low.
REQ-006 Port: clear, input, 1, synchronous clear of statistics (hit_mask, en_cnt).
REQ-007 Port: out, output, 8, combinational one-hot decode of select, qualified by enable.
REQ-008 Port: out_q, output, 8, registered copy of out, one clk of latency.
REQ-009 Port: hit_mask, output, 8, sticky record of every out bit asserted since reset/clear.
REQ-010 Port: en_cnt, output, CNT_W, saturating count of clk cycles sampled with enable=1.
REQ-011 Port: onehot_err, output, 1, registered flag, high if out_q is neither all-zero nor one-hot.

Function
REQ-012 out SHALL be purely combinational, with no dependence on clk or rst_n.
REQ-013 With enable=0, out SHALL be 8'b00000000 for every select value.
REQ-014 With enable=1, out SHALL be 8'b1 shifted left by select, i.e. out[k]=1 iff select==k (000->00000001 ... 111->10000000).
REQ-015 out SHALL settle within the same delta time as an input change; no clock edge is required.
REQ-016 out_q SHALL load out on every rising clk edge while rst_n=1.
REQ-017 On each rising edge with rst_n=1 and clear=0, hit_mask SHALL become hit_mask OR out.
REQ-018 On each rising edge with rst_n=1 and clear=1, hit_mask SHALL load out, so the current cycle counts as a hit.
REQ-019 On each rising edge with rst_n=1 and clear=0, en_cnt SHALL increment by 1 when enable=1.
REQ-020 en_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 On a rising edge with clear=1, en_cnt SHALL load 1 if enable=1, otherwise 0 (clear has priority over accumulation).
REQ-022 onehot_err SHALL register whether out (next out_q) has more than one bit set; by construction it SHALL always be 0 and serves as an assertion hook.
REQ-023 Mid-cycle changes of select or enable SHALL affect out immediately; out_q, hit_mask and en_cnt SHALL use only values sampled at the clock edge.

Reset
REQ-024 When rst_n=0 at a rising edge: out_q=0, hit_mask=0, en_cnt=0 and onehot_err=0; clear is ignored.
REQ-025 Reset SHALL NOT affect out, which keeps tracking select and enable during reset.
REQ-026 Reset asserted mid-operation SHALL discard all accumulated statistics on that edge.
REQ-027 The first statistics update SHALL occur on the first rising edge with rst_n=1.

Structure
REQ-028 Constants SEL_W=3 and OUT_W=8 SHALL live in the shared package decoder_pkg, alongside any one-hot helper function.
REQ-029 The combinational decode SHALL be a sub-module, dec_core (inputs select and enable, output out), instantiated once.
REQ-030 The registers (out_q, hit_mask, en_cnt, onehot_err) SHALL be in the top level.
REQ-031 The design SHALL contain no latches; every combinational path SHALL assign a default.

Verification
REQ-032 enable=0 with select swept 0..7, check 10 time units after each change -> out=00000000 for every value.
REQ-033 enable=1 with select swept 000..111 -> out = 00000001, 00000010, 00000100, 00001000, 00010000, 00100000, 01000000, 10000000 in that order.
REQ-034 After reset, enable=1 with select=2 then 5 on consecutive edges -> out_q follows one cycle late; hit_mask=00100100; en_cnt=2.
REQ-035 Hold enable=1 for 2^CNT_W+3 cycles (CNT_W=4) -> en_cnt stops at 15; clear=1 with enable=1 -> en_cnt=1.
REQ-036 Drive rst_n=0 for one edge mid-run -> out_q, hit_mask, en_cnt and onehot_err are 0 after that edge while out still decodes live inputs.
REQ-037 Random select and enable for 1000 cycles -> onehot_err never asserts and out always matches the reference decode.
